// File: rtl/branch_redirect_pkg.sv
// Shared constants for fetch-side branch handling: opcode, counter states, funct3 codes.
// Also provides the saturating-counter step used when training the history table.
package branch_redirect_pkg;

   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   typedef enum logic [1:0] {
      CTR_SNT = 2'b00,
      CTR_WNT = 2'b01,
      CTR_WT  = 2'b10,
      CTR_ST  = 2'b11
   } ctr_e;

   localparam logic [2:0] BR_BEQ  = 3'b000;
   localparam logic [2:0] BR_BNE  = 3'b001;
   localparam logic [2:0] BR_BLT  = 3'b100;
   localparam logic [2:0] BR_BGE  = 3'b101;
   localparam logic [2:0] BR_BLTU = 3'b110;
   localparam logic [2:0] BR_BGEU = 3'b111;

   function automatic logic [1:0] ctr_next(input logic [1:0] c, input logic taken);
      if (taken) return (c == CTR_ST)  ? c : c + 2'd1;
      else       return (c == CTR_SNT) ? c : c - 2'd1;
   endfunction

endpackage

// File: rtl/branch_redirect_predecode.sv
// b_predecode: flags B-type instructions and extracts the sign-extended branch offset.
// Purely combinational; sits directly on the instruction-memory read data.
module b_predecode
   import branch_redirect_pkg::*;
(
   input  logic [31:0] instr,
   output logic        is_btype,
   output logic [31:0] imm
);

   // rs1/rs2/funct3 are irrelevant to fetch-side prediction
   logic unused_fields;
   assign unused_fields = ^instr[24:12];

   always_comb begin
      is_btype = (instr[6:0] == OP_BRANCH);
      imm      = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
   end

endmodule

// File: rtl/branch_redirect.sv
// Fetch PC owner with 2-bit counter branch prediction and execute-driven redirect.
// `BRANCH_PREDICT_EN enables the counter table; without it fetch is static not-taken.
module branch_redirect
   import branch_redirect_pkg::*;
#(
   parameter logic [31:0] RESET_PC    = 32'h0000_0000,
   parameter int          BHT_ENTRIES = 64
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall,
   input  logic [31:0] if_instr,
   output logic [31:0] pc,
   output logic        if_pred_taken,
   input  logic        ex_valid,
   input  logic        ex_can_branch,
   input  logic        ex_will_branch,
   input  logic        ex_pred_taken,
   input  logic [31:0] ex_pc,
   input  logic [31:0] ex_target,
   output logic        flush
);

   logic        is_btype;
   logic [31:0] imm;
   logic [31:0] pc_q, pc_d;
   logic [31:0] corr_pc;
   logic        res, mis, pred;

   b_predecode u_predecode (
      .instr    (if_instr),
      .is_btype (is_btype),
      .imm      (imm)
   );

`ifdef BRANCH_PREDICT_EN
   localparam int IDX_W = $clog2(BHT_ENTRIES);

   logic [BHT_ENTRIES-1:0][1:0] ctr_q, ctr_d;
   logic [IDX_W-1:0]            if_idx, ex_idx;

   assign if_idx = pc_q[IDX_W+1:2];
   assign ex_idx = ex_pc[IDX_W+1:2];
   // Reads ctr_q, so a same-cycle update to this index is not visible yet
   assign pred   = is_btype & ctr_q[if_idx][1];

   always_comb begin
      ctr_d = ctr_q;
      if (res) ctr_d[ex_idx] = ctr_next(ctr_q[ex_idx], ex_will_branch);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < BHT_ENTRIES; i++) ctr_q[i] <= CTR_WNT;
      end else begin
         ctr_q <= ctr_d;
      end
   end
`else
   localparam int unused_bht_entries = BHT_ENTRIES;
   logic unused_btype;
   assign unused_btype = is_btype;
   assign pred         = 1'b0;
`endif

   assign res     = ex_valid & ex_can_branch;
   assign mis     = res & (ex_will_branch != ex_pred_taken);
   assign corr_pc = ex_will_branch ? ex_target : ex_pc + 32'd4;

   // A resolved mispredict outranks stall: the wrong path must never be held
   always_comb begin
      pc_d = pc_q + 32'd4;
      if (mis)       pc_d = corr_pc;
      else if (stall) pc_d = pc_q;
      else if (pred)  pc_d = pc_q + imm;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) pc_q <= RESET_PC;
      else        pc_q <= pc_d;
   end

   assign pc            = pc_q;
   assign if_pred_taken = pred;
   assign flush         = mis;

endmodule
